h75_fb_write_arbiter: RTL and testbench

Framebuffer write-side controller for the HUB75 block, in the 50 MHz `clk` domain between the APB register interface and the framebuffer memory write port. It arbitrates single APB pixel writes against a built-in fill/clear engine onto one `wr_en`/`wr_addr`/`wr_data` port. It manages double buffering: writes go to the back page, and page swaps apply only at a frame boundary signalled by the LED-domain `frame_sync`.

---
 rtl/h75_pkg.sv | 28 ++
 rtl/h75_sync_edge.sv | 47 ++++
 rtl/h75_fb_write_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_h75_fb_write_arbiter.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h75_pkg.sv
// ---------------------------------------------------------------------------
// h75_pkg
// Shared definitions for the HUB75 framebuffer blocks: geometry constants,
// the fill-engine state encoding and the write-grant source encoding.
// ---------------------------------------------------------------------------
package h75_pkg;

    localparam int H75_ADDR_W   = 14;
    localparam int H75_DATA_W   = 16;
    localparam int H75_FB_DEPTH = 2 ** H75_ADDR_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

    typedef enum logic {
        GNT_APB  = 1'b0,
        GNT_FILL = 1'b1
    } gnt_src_e;

    // Round-robin pick when both requesters are valid: whoever was not
    // served last goes next.
    function automatic gnt_src_e rr_pick(input gnt_src_e last_grant);
        return (last_grant == GNT_FILL) ? GNT_APB : GNT_FILL;
    endfunction

endpackage

// File: rtl/h75_sync_edge.sv
// ---------------------------------------------------------------------------
// h75_sync_edge
// Two-flop synchronizer for a level from the LED clock domain followed by a
// rising-edge detector. Used for any LED->memory domain strobe.
//   clk     in  destination clock
//   resetn  in  synchronous active-low reset
//   async_i in  asynchronous level
//   rise_o  out one-cycle pulse on each synchronized rising edge
// ---------------------------------------------------------------------------
module h75_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;
    logic prev_q;
    logic prev_d;

    // Next-state for the synchronizer chain and the edge-history flop.
    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Edge is formed only from flops past the metastability stage.
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/h75_fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// h75_fb_write_arbiter
// Framebuffer write-side controller. Merges single APB pixel writes and a
// whole-page fill engine onto one registered memory write port, and owns the
// double-buffer page select, flipping it only on a frame boundary.
//   clk, resetn        clock, synchronous active-low reset
//   apb_req/addr/data  APB write request (held until apb_ack)
//   apb_ack            one-cycle pulse when the APB write is issued
//   fill_start/value   start filling the back page with a constant
//   fill_busy/done     fill in progress / pulse on final fill write
//   swap_req           request a page flip
//   swap_pending/done  flip waiting / pulse when applied
//   frame_sync_async   frame-start level from the LED domain
//   front_page         page currently displayed
//   wr_en/addr/data    memory write port, addr MSB = target page
// ---------------------------------------------------------------------------
module h75_fb_write_arbiter
    import h75_pkg::*;
#(
    parameter int ADDR_W = H75_ADDR_W,
    parameter int DATA_W = H75_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              apb_req,
    input  logic [ADDR_W-1:0] apb_addr,
    input  logic [DATA_W-1:0] apb_data,
    output logic              apb_ack,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    input  logic              frame_sync_async,
    output logic              front_page,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W-1:0] LAST_WORD = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE_WORD  = ADDR_W'(1);

    fill_state_e       fill_state_q, fill_state_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0] fill_val_q, fill_val_d;
    gnt_src_e          last_grant_q, last_grant_d;
    logic              swap_pending_q, swap_pending_d;
    logic              front_page_q, front_page_d;
    logic              swap_done_q, swap_done_d;
    logic              fill_busy_q, fill_busy_d;
    logic              fill_done_q, fill_done_d;
    logic              apb_ack_q, apb_ack_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic apb_valid_s;
    logic fill_valid_s;
    logic gnt_apb_s;
    logic gnt_fill_s;
    logic fill_last_s;
    logic fs_edge_s;

    h75_sync_edge u_fs_sync (
        .clk     (clk),
        .resetn  (resetn),
        .async_i (frame_sync_async),
        .rise_o  (fs_edge_s)
    );

    // Arbitration. A held apb_req is masked in its own ack cycle so one
    // request is never issued twice.
    always_comb begin
        apb_valid_s  = apb_req & ~apb_ack_q;
        fill_valid_s = (fill_state_q == ST_FILL);
        gnt_apb_s    = 1'b0;
        gnt_fill_s   = 1'b0;
        if (apb_valid_s && fill_valid_s) begin
            if (rr_pick(last_grant_q) == GNT_APB) begin
                gnt_apb_s = 1'b1;
            end else begin
                gnt_fill_s = 1'b1;
            end
        end else if (apb_valid_s) begin
            gnt_apb_s = 1'b1;
        end else if (fill_valid_s) begin
            gnt_fill_s = 1'b1;
        end else begin
            gnt_apb_s  = 1'b0;
            gnt_fill_s = 1'b0;
        end

        last_grant_d = last_grant_q;
        if (gnt_apb_s) begin
            last_grant_d = GNT_APB;
        end else if (gnt_fill_s) begin
            last_grant_d = GNT_FILL;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Fill engine: walks every word of the back page, advancing only on grant.
    always_comb begin
        fill_state_d = fill_state_q;
        fill_cnt_d   = fill_cnt_q;
        fill_val_d   = fill_val_q;
        fill_last_s  = 1'b0;
        case (fill_state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    fill_state_d = ST_FILL;
                    fill_cnt_d   = {ADDR_W{1'b0}};
                    fill_val_d   = fill_value;
                end else begin
                    fill_state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (gnt_fill_s) begin
                    fill_cnt_d = fill_cnt_q + ONE_WORD;
                    if (fill_cnt_q == LAST_WORD) begin
                        fill_state_d = ST_IDLE;
                        fill_last_s  = 1'b1;
                    end else begin
                        fill_state_d = ST_FILL;
                    end
                end else begin
                    fill_state_d = ST_FILL;
                end
            end
            default: begin
                fill_state_d = ST_IDLE;
            end
        endcase
    end

    // Page swap. A flip needs a frame edge, a pending request and no fill in
    // flight; a request arriving with the edge waits for the next one.
    always_comb begin
        swap_pending_d = swap_pending_q;
        front_page_d   = front_page_q;
        swap_done_d    = 1'b0;
        if (fs_edge_s && swap_pending_q && !fill_busy_q) begin
            front_page_d   = ~front_page_q;
            swap_pending_d = 1'b0;
            swap_done_d    = 1'b1;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end else begin
            swap_pending_d = swap_pending_q;
        end
    end

    // Write port and status. The page MSB uses the pre-flip front page, so a
    // grant coinciding with a flip still lands on the old back page.
    always_comb begin
        wr_en_d     = gnt_apb_s | gnt_fill_s;
        apb_ack_d   = gnt_apb_s;
        wr_addr_d   = {(ADDR_W + 1){1'b0}};
        wr_data_d   = {DATA_W{1'b0}};
        if (gnt_apb_s) begin
            wr_addr_d = {~front_page_q, apb_addr};
            wr_data_d = apb_data;
        end else if (gnt_fill_s) begin
            wr_addr_d = {~front_page_q, fill_cnt_q};
            wr_data_d = fill_val_q;
        end else begin
            wr_addr_d = {(ADDR_W + 1){1'b0}};
            wr_data_d = {DATA_W{1'b0}};
        end
        // Busy covers the cycle that carries the final fill write.
        fill_busy_d = (fill_state_d == ST_FILL) | fill_last_s;
        fill_done_d = fill_last_s;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fill_state_q   <= ST_IDLE;
            fill_cnt_q     <= {ADDR_W{1'b0}};
            fill_val_q     <= {DATA_W{1'b0}};
            last_grant_q   <= GNT_FILL;
            swap_pending_q <= 1'b0;
            front_page_q   <= 1'b0;
            swap_done_q    <= 1'b0;
            fill_busy_q    <= 1'b0;
            fill_done_q    <= 1'b0;
            apb_ack_q      <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= {(ADDR_W + 1){1'b0}};
            wr_data_q      <= {DATA_W{1'b0}};
        end else begin
            fill_state_q   <= fill_state_d;
            fill_cnt_q     <= fill_cnt_d;
            fill_val_q     <= fill_val_d;
            last_grant_q   <= last_grant_d;
            swap_pending_q <= swap_pending_d;
            front_page_q   <= front_page_d;
            swap_done_q    <= swap_done_d;
            fill_busy_q    <= fill_busy_d;
            fill_done_q    <= fill_done_d;
            apb_ack_q      <= apb_ack_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
        end
    end

    assign apb_ack      = apb_ack_q;
    assign fill_busy    = fill_busy_q;
    assign fill_done    = fill_done_q;
    assign swap_pending = swap_pending_q;
    assign swap_done    = swap_done_q;
    assign front_page   = front_page_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_h75_fb_write_arbiter.sv
`timescale 1ns/1ps
module tb_h75_fb_write_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk              = 1'b0;
    logic          resetn           = 1'b0;
    logic          apb_req          = 1'b0;
    logic [AW-1:0] apb_addr         = '0;
    logic [DW-1:0] apb_data         = '0;
    logic          fill_start       = 1'b0;
    logic [DW-1:0] fill_value       = '0;
    logic          swap_req         = 1'b0;
    logic          frame_sync_async = 1'b0;
    logic          apb_ack;
    logic          fill_busy;
    logic          fill_done;
    logic          swap_pending;
    logic          swap_done;
    logic          front_page;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [DW-1:0] wr_data;

    int vectors     = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    h75_fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .apb_req          (apb_req),
        .apb_addr         (apb_addr),
        .apb_data         (apb_data),
        .apb_ack          (apb_ack),
        .fill_start       (fill_start),
        .fill_value       (fill_value),
        .fill_busy        (fill_busy),
        .fill_done        (fill_done),
        .swap_req         (swap_req),
        .swap_pending     (swap_pending),
        .swap_done        (swap_done),
        .frame_sync_async (frame_sync_async),
        .front_page       (front_page),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        vectors++;
        if ({wr_en, apb_ack, fill_busy, fill_done, swap_pending, swap_done, front_page} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {wr_en, apb_ack, fill_busy, fill_done, swap_pending, swap_done, front_page});
        end
        vectors++;
        if (wr_addr !== 15'h0000) begin
            miscompares++;
            $display("FAIL reset_addr: got %h expected 0000", wr_addr);
        end
        vectors++;
        if (wr_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0000", wr_data);
        end
        resetn = 1'b1;
        tick();
        vectors++;
        if (wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: wr_en got %b expected 0", wr_en);
        end
    endtask

    task automatic test_single_apb();
        int extra;
        extra    = 0;
        apb_addr = 14'h0123;
        apb_data = 16'hF00D;
        apb_req  = 1'b1;
        tick();
        vectors++;
        if ({wr_en, apb_ack} !== 2'b11) begin
            miscompares++;
            $display("FAIL apb_strobe: wr_en/ack got %b expected 11", {wr_en, apb_ack});
        end
        vectors++;
        if (wr_addr !== 15'h4123) begin
            miscompares++;
            $display("FAIL apb_addr: got %h expected 4123", wr_addr);
        end
        vectors++;
        if (wr_data !== 16'hF00D) begin
            miscompares++;
            $display("FAIL apb_data: got %h expected f00d", wr_data);
        end
        apb_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wr_en === 1'b1 || apb_ack === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL apb_single_write: extra writes got %0d expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW:0]   exp_addr;
        logic [DW-1:0] exp_data;
        logic          exp_en;
        exp_addr = 15'h4200;
        exp_data = 16'h1111;
        apb_addr = 14'h0200;
        apb_data = 16'h1111;
        apb_req  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_en = ((i % 2) == 0);
            vectors++;
            if (wr_en !== exp_en || apb_ack !== exp_en) begin
                miscompares++;
                $display("FAIL b2b_strobe[%0d]: wr_en/ack got %b%b expected %b%b",
                         i, wr_en, apb_ack, exp_en, exp_en);
            end
            if (exp_en) begin
                vectors++;
                if (wr_addr !== exp_addr || wr_data !== exp_data) begin
                    miscompares++;
                    $display("FAIL b2b_write[%0d]: got %h/%h expected %h/%h",
                             i, wr_addr, wr_data, exp_addr, exp_data);
                end
                exp_addr = exp_addr + 15'd1;
                exp_data = exp_data + 16'd1;
            end
            if (apb_ack === 1'b1) begin
                apb_addr = apb_addr + 14'd1;
                apb_data = apb_data + 16'd1;
            end
        end
        apb_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_fill_uncontended();
        int          bad;
        int          first_bad;
        int          early_done;
        logic [AW:0] exp_addr;
        bad        = 0;
        first_bad  = -1;
        early_done = 0;
        exp_addr   = 15'h4000;
        fill_value = 16'h0000;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        vectors++;
        if ({fill_busy, wr_en} !== 2'b10) begin
            miscompares++;
            $display("FAIL fill_busy_rise: busy/wr_en got %b expected 10", {fill_busy, wr_en});
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (wr_en !== 1'b1 || wr_addr !== exp_addr || wr_data !== 16'h0000 || fill_busy !== 1'b1) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
            if (i < DEPTH - 1 && fill_done !== 1'b0) early_done++;
            exp_addr = exp_addr + 15'd1;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL fill_sequence: %0d bad cycles (first %0d) expected 0", bad, first_bad);
        end
        vectors++;
        if (early_done !== 0) begin
            miscompares++;
            $display("FAIL fill_done_early: got %0d early pulses expected 0", early_done);
        end
        vectors++;
        if (fill_done !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_done_last: got %b expected 1", fill_done);
        end
        tick();
        vectors++;
        if ({fill_busy, fill_done, wr_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL fill_end: busy/done/wr_en got %b expected 000", {fill_busy, fill_done, wr_en});
        end
    endtask

    task automatic test_contention();
        int            writes;
        int            fills;
        int            acks;
        int            order_err;
        int            gaps;
        bit            done_seen;
        bit            exp_apb;
        logic [AW-1:0] exp_word;
        writes    = 0;
        fills     = 0;
        acks      = 0;
        order_err = 0;
        gaps      = 0;
        done_seen = 1'b0;
        exp_word  = '0;
        fill_value = 16'hA5A5;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        apb_addr   = 14'h0042;
        apb_data   = 16'h1234;
        apb_req    = 1'b1;
        for (int c = 0; c < DEPTH + 140 && !done_seen; c++) begin
            tick();
            if (wr_en === 1'b1) begin
                exp_apb = (writes < 200) && ((writes % 2) == 0);
                if (exp_apb) begin
                    if (wr_addr !== 15'h4042 || wr_data !== 16'h1234 || apb_ack !== 1'b1) order_err++;
                end else begin
                    if (wr_addr !== {1'b1, exp_word} || wr_data !== 16'hA5A5 || apb_ack !== 1'b0) order_err++;
                    exp_word = exp_word + 14'd1;
                    fills++;
                end
                writes++;
            end else if (writes > 0) begin
                gaps++;
            end
            if (apb_ack === 1'b1) begin
                acks++;
                if (acks == 100) apb_req = 1'b0;
            end
            if (fill_done === 1'b1) done_seen = 1'b1;
        end
        apb_req = 1'b0;
        vectors++;
        if (done_seen !== 1'b1) begin
            miscompares++;
            $display("FAIL cont_done: fill_done seen %b expected 1", done_seen);
        end
        vectors++;
        if (writes !== DEPTH + 100 || fills !== DEPTH) begin
            miscompares++;
            $display("FAIL cont_count: writes/fills got %0d/%0d expected %0d/%0d",
                     writes, fills, DEPTH + 100, DEPTH);
        end
        vectors++;
        if (acks !== 100) begin
            miscompares++;
            $display("FAIL cont_acks: got %0d expected 100", acks);
        end
        vectors++;
        if (order_err !== 0) begin
            miscompares++;
            $display("FAIL cont_order: got %0d misordered writes expected 0", order_err);
        end
        vectors++;
        if (gaps !== 0) begin
            miscompares++;
            $display("FAIL cont_gaps: got %0d idle cycles expected 0", gaps);
        end
        tick();
        vectors++;
        if (fill_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_busy_end: got %b expected 0", fill_busy);
        end
    endtask

    task automatic test_swap();
        int flip_at;
        int done_at;
        int dones;
        flip_at = 0;
        done_at = 0;
        dones   = 0;
        vectors++;
        if (front_page !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_pre_front: got %b expected 0", front_page);
        end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        vectors++;
        if (swap_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL swap_pending_set: got %b expected 1", swap_pending);
        end
        frame_sync_async = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (front_page === 1'b1 && flip_at == 0) flip_at = c;
            if (swap_done === 1'b1) begin
                dones++;
                done_at = c;
            end
        end
        vectors++;
        if (flip_at < 1 || flip_at > 4) begin
            miscompares++;
            $display("FAIL swap_latency: flip at cycle %0d expected 1..4", flip_at);
        end
        vectors++;
        if (dones !== 1 || done_at !== flip_at) begin
            miscompares++;
            $display("FAIL swap_done_pulse: %0d pulses at %0d expected 1 at %0d", dones, done_at, flip_at);
        end
        vectors++;
        if (swap_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_pending_clr: got %b expected 0", swap_pending);
        end
        frame_sync_async = 1'b0;
        apb_addr = 14'h0010;
        apb_data = 16'hBEEF;
        apb_req  = 1'b1;
        tick();
        apb_req = 1'b0;
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 15'h0010 || wr_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL swap_back_page: got %b/%h/%h expected 1/0010/beef", wr_en, wr_addr, wr_data);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_fill();
        bit hit;
        hit        = 1'b0;
        fill_value = 16'h7777;
        fill_start = 1'b1;
        swap_req   = 1'b1;
        tick();
        fill_start = 1'b0;
        swap_req   = 1'b0;
        for (int c = 0; c < DEPTH && !hit; c++) begin
            tick();
            if (wr_en === 1'b1 && wr_addr[AW-1:0] === 14'h1000) hit = 1'b1;
        end
        vectors++;
        if (hit !== 1'b1 || wr_addr !== 15'h1000 || {swap_pending, front_page, fill_busy} !== 3'b111) begin
            miscompares++;
            $display("FAIL rst_precond: hit %b addr %h pend/front/busy %b expected 1 1000 111",
                     hit, wr_addr, {swap_pending, front_page, fill_busy});
        end
        resetn = 1'b0;
        tick();
        vectors++;
        if ({wr_en, apb_ack, fill_busy, fill_done, swap_pending, swap_done, front_page} !== 7'b0 ||
            wr_addr !== 15'h0000 || wr_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_mid_fill: flags %b addr %h data %h expected all 0",
                     {wr_en, apb_ack, fill_busy, fill_done, swap_pending, swap_done, front_page},
                     wr_addr, wr_data);
        end
        resetn = 1'b1;
        tick();
        vectors++;
        if ({wr_en, fill_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_fsm_idle: wr_en/busy got %b expected 00", {wr_en, fill_busy});
        end
        fill_value = 16'h3C3C;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        tick();
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 15'h4000 || wr_data !== 16'h3C3C) begin
            miscompares++;
            $display("FAIL rst_restart_w0: got %b/%h/%h expected 1/4000/3c3c", wr_en, wr_addr, wr_data);
        end
        tick();
        vectors++;
        if (wr_addr !== 15'h4001) begin
            miscompares++;
            $display("FAIL rst_restart_w1: got %h expected 4001", wr_addr);
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_swap_blocked();
        int wrong_page;
        int early_flip;
        int fills;
        int flip_at;
        bit done_seen;
        wrong_page = 0;
        early_flip = 0;
        fills      = 0;
        flip_at    = 0;
        done_seen  = 1'b0;
        fill_value = 16'h5A5A;
        fill_start = 1'b1;
        swap_req   = 1'b1;
        tick();
        fill_start = 1'b0;
        swap_req   = 1'b0;
        vectors++;
        if ({fill_busy, swap_pending, front_page} !== 3'b110) begin
            miscompares++;
            $display("FAIL blk_start: busy/pend/front got %b expected 110", {fill_busy, swap_pending, front_page});
        end
        for (int c = 0; c < DEPTH + 10 && !done_seen; c++) begin
            frame_sync_async = (c >= 100 && c < 104) || (c >= 5000 && c < 5004);
            swap_req         = (c == 3000);
            tick();
            if (front_page !== 1'b0 || swap_done !== 1'b0 || swap_pending !== 1'b1) early_flip++;
            if (wr_en === 1'b1) begin
                fills++;
                if (wr_addr[AW] !== 1'b1) wrong_page++;
            end
            if (fill_done === 1'b1) done_seen = 1'b1;
        end
        frame_sync_async = 1'b0;
        swap_req         = 1'b0;
        vectors++;
        if (done_seen !== 1'b1 || fills !== DEPTH) begin
            miscompares++;
            $display("FAIL blk_fill: done %b fills %0d expected 1 %0d", done_seen, fills, DEPTH);
        end
        vectors++;
        if (early_flip !== 0) begin
            miscompares++;
            $display("FAIL blk_no_flip: got %0d bad cycles expected 0", early_flip);
        end
        vectors++;
        if (wrong_page !== 0) begin
            miscompares++;
            $display("FAIL blk_page: got %0d writes to wrong page expected 0", wrong_page);
        end
        tick();
        vectors++;
        if ({fill_busy, swap_pending, front_page} !== 3'b010) begin
            miscompares++;
            $display("FAIL blk_after_fill: busy/pend/front got %b expected 010", {fill_busy, swap_pending, front_page});
        end
        frame_sync_async = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (front_page === 1'b1 && flip_at == 0) flip_at = c;
        end
        frame_sync_async = 1'b0;
        vectors++;
        if (flip_at < 1 || flip_at > 4 || swap_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL blk_late_flip: flip at %0d pend %b expected 1..4 0", flip_at, swap_pending);
        end
    endtask

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_apb();
        test_back_to_back();
        test_fill_uncontended();
        test_contention();
        test_swap();
        test_reset_mid_fill();
        test_swap_blocked();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
